dds_ctrl_word_gen: RTL and testbench



---
 rtl/dds_ctrl_word_gen.sv | 128 ++++++++++++
 tb/tb_dds_ctrl_word_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_ctrl_word_gen.sv
// Key-driven generator of per-channel DDS frequency/phase words with edge-detected
// commands, auto-repeat on held step keys, step scaling and channel selection.
module dds_ctrl_word_gen #(
    parameter int W          = 16,
    parameter int CH         = 2,
    parameter int FRE_INIT   = 500,
    parameter int FRE_STEP   = 50,
    parameter int PHA_STEP   = 1000,
    parameter int SAT        = 0,
    parameter int REPEAT_DLY = 1000,
    parameter int REPEAT_PER = 200,
    localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_value,
    output logic [CH*W-1:0]   fre_data,
    output logic [CH*W-1:0]   pha_data,
    output logic [CHW-1:0]    ch_sel,
    output logic [1:0]        step_sel,
    output logic              upd
);

    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CW   = $clog2(RMAX + 1);
    localparam logic [W-1:0] FRE_INIT_W = W'(FRE_INIT);

    logic [CH-1:0][W-1:0] r_fre;
    logic [CH-1:0][W-1:0] r_pha;
    logic [CHW-1:0]       r_ch;
    logic [1:0]           r_step;
    logic                 r_upd;
    logic [3:0]           r_key_prev;
    logic [CW-1:0]        r_cnt;

    logic                 w_rep_key;
    logic                 w_press;
    logic                 w_held;
    logic                 w_fire;
    logic                 w_exec;
    logic [CW-1:0]        w_cnt_nxt;
    logic [W-1:0]         w_fre_step;
    logic [W-1:0]         w_pha_step;
    logic [W-1:0]         w_fre_cur;
    logic [W-1:0]         w_pha_cur;
    logic [W-1:0]         w_fre_nxt;
    logic [W-1:0]         w_pha_nxt;
    logic [W:0]           w_fre_add;
    logic [W:0]           w_fre_sub;

    // r_cnt counts down to the next repeat event; 0 means idle, so it can never
    // wrap into a spurious event. A load of 0 (REPEAT_DLY=0) disables repeat.
    always_comb begin
        w_rep_key = (key_value >= 4'd1) && (key_value <= 4'd4);
        w_press   = (key_value != 4'd0) && (key_value != r_key_prev);
        w_held    = (key_value != 4'd0) && (key_value == r_key_prev);
        w_fire    = w_press || (w_held && w_rep_key && (r_cnt == CW'(1)));
        w_exec    = w_fire && !key_value[3];
        w_cnt_nxt = '0;
        if (w_press)
            w_cnt_nxt = w_rep_key ? CW'(REPEAT_DLY) : '0;
        else if (w_held && (r_cnt != '0))
            w_cnt_nxt = (r_cnt == CW'(1)) ? CW'(REPEAT_PER) : r_cnt - CW'(1);
    end

    always_comb begin
        w_fre_step = W'(FRE_STEP) << {r_step, 1'b0};
        w_pha_step = W'(PHA_STEP) << {r_step, 1'b0};
        w_fre_cur  = '0;
        w_pha_cur  = '0;
        for (int n = 0; n < CH; n++) begin
            if (r_ch == CHW'(n)) begin
                w_fre_cur = r_fre[n];
                w_pha_cur = r_pha[n];
            end
        end
        w_fre_add = {1'b0, w_fre_cur} + {1'b0, w_fre_step};
        w_fre_sub = {1'b0, w_fre_cur} - {1'b0, w_fre_step};
        w_fre_nxt = w_fre_cur;
        w_pha_nxt = w_pha_cur;
        case (key_value)
            4'd1: w_fre_nxt = ((SAT != 0) && w_fre_add[W]) ? '1 : w_fre_add[W-1:0];
            4'd2: w_fre_nxt = ((SAT != 0) && w_fre_sub[W]) ? '0 : w_fre_sub[W-1:0];
            4'd3: w_pha_nxt = w_pha_cur + w_pha_step;
            4'd4: w_pha_nxt = w_pha_cur - w_pha_step;
            4'd7: begin
                w_fre_nxt = FRE_INIT_W;
                w_pha_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fre      <= {CH{FRE_INIT_W}};
            r_pha      <= '0;
            r_ch       <= '0;
            r_step     <= '0;
            r_upd      <= 1'b0;
            r_key_prev <= '0;
            r_cnt      <= '0;
        end else begin
            r_key_prev <= key_value;
            r_cnt      <= w_cnt_nxt;
            r_upd      <= w_exec;
            if (w_exec) begin
                for (int n = 0; n < CH; n++) begin
                    if (r_ch == CHW'(n)) begin
                        r_fre[n] <= w_fre_nxt;
                        r_pha[n] <= w_pha_nxt;
                    end
                end
                if (key_value == 4'd5)
                    r_ch <= (r_ch == CHW'(CH - 1)) ? '0 : r_ch + CHW'(1);
                if (key_value == 4'd6)
                    r_step <= r_step + 2'd1;
            end
        end
    end

    assign fre_data = r_fre;
    assign pha_data = r_pha;
    assign ch_sel   = r_ch;
    assign step_sel = r_step;
    assign upd      = r_upd;

endmodule

// File: tb/tb_dds_ctrl_word_gen.sv
// Drives a wrapping and a saturating instance with the same key stream and compares
// both against an edge-count based reference model every cycle.
module tb_dds_ctrl_word_gen;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam int FI = 500;
    localparam int FS = 50;
    localparam int PS = 1000;
    localparam int RD = 10;
    localparam int RP = 4;
    localparam int CHW = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       key_value = 4'd0;
    logic [CH*W-1:0]  fre_s0, pha_s0, fre_s1, pha_s1;
    logic [CHW-1:0]   ch_s0, ch_s1;
    logic [1:0]       ss_s0, ss_s1;
    logic             upd_s0, upd_s1;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dds_ctrl_word_gen #(.W(W), .CH(CH), .FRE_INIT(FI), .FRE_STEP(FS), .PHA_STEP(PS),
        .SAT(0), .REPEAT_DLY(RD), .REPEAT_PER(RP)) u_wrap (
        .clk(clk), .rst(rst), .key_value(key_value), .fre_data(fre_s0), .pha_data(pha_s0),
        .ch_sel(ch_s0), .step_sel(ss_s0), .upd(upd_s0));

    dds_ctrl_word_gen #(.W(W), .CH(CH), .FRE_INIT(FI), .FRE_STEP(FS), .PHA_STEP(PS),
        .SAT(1), .REPEAT_DLY(RD), .REPEAT_PER(RP)) u_sat (
        .clk(clk), .rst(rst), .key_value(key_value), .fre_data(fre_s1), .pha_data(pha_s1),
        .ch_sel(ch_s1), .step_sel(ss_s1), .upd(upd_s1));

    // Reference model: m_hold = edges since the last press (-1 when no key held).
    int m_fre [2][CH];
    int m_pha [CH];
    int m_ch, m_ss, m_upd, m_prev, m_hold;

    always @(posedge clk) begin : model
        int code, step, v;
        bit fire;
        code = int'(key_value);
        fire = 1'b0;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_fre[0][c] = FI; m_fre[1][c] = FI; m_pha[c] = 0;
            end
            m_ch = 0; m_ss = 0; m_upd = 0; m_prev = 0; m_hold = -1;
        end else begin
            if (code != 0 && code != m_prev) begin
                fire = 1'b1; m_hold = 0;
            end else if (code != 0) begin
                if (m_hold >= 0) m_hold++;
                if (code <= 4 && m_hold > 0 &&
                    (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)))
                    fire = 1'b1;
            end else begin
                m_hold = -1;
            end
            m_prev = code;
            m_upd  = (fire && code >= 1 && code <= 7) ? 1 : 0;
            if (m_upd != 0) begin
                case (code)
                    1, 2: begin
                        step = (FS * (1 << (2 * m_ss))) % 65536;
                        for (int s = 0; s < 2; s++) begin
                            v = (code == 1) ? m_fre[s][m_ch] + step : m_fre[s][m_ch] - step;
                            if (s == 1) v = (v > 65535) ? 65535 : (v < 0) ? 0 : v;
                            else        v = (v + 65536) % 65536;
                            m_fre[s][m_ch] = v;
                        end
                    end
                    3: m_pha[m_ch] = (m_pha[m_ch] + (PS * (1 << (2 * m_ss)))) % 65536;
                    4: m_pha[m_ch] = (m_pha[m_ch] - (PS * (1 << (2 * m_ss))) % 65536 + 65536) % 65536;
                    5: m_ch = (m_ch + 1) % CH;
                    6: m_ss = (m_ss + 1) % 4;
                    7: begin m_fre[0][m_ch] = FI; m_fre[1][m_ch] = FI; m_pha[m_ch] = 0; end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk("fre_wrap", 32'(fre_s0[c*W +: W]), 32'(m_fre[0][c]));
            chk("fre_sat",  32'(fre_s1[c*W +: W]), 32'(m_fre[1][c]));
            chk("pha_wrap", 32'(pha_s0[c*W +: W]), 32'(m_pha[c]));
            chk("pha_sat",  32'(pha_s1[c*W +: W]), 32'(m_pha[c]));
        end
        chk("ch_sel",   32'(ch_s0),  32'(m_ch));
        chk("ch_sel_s", 32'(ch_s1),  32'(m_ch));
        chk("step_sel", 32'(ss_s0),  32'(m_ss));
        chk("step_sel_s", 32'(ss_s1), 32'(m_ss));
        chk("upd",      32'(upd_s0), 32'(m_upd));
        chk("upd_s",    32'(upd_s1), 32'(m_upd));
    endtask

    // Apply key k for n edges, checking after each edge.
    task automatic run(input logic [3:0] k, input int n);
        repeat (n) begin
            key_value = k;
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(4'd0, 2);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [3:0] k;

        do_reset();
        chk("rst_fre0", 32'(fre_s0[0 +: W]), 32'd500);
        chk("rst_pha1", 32'(pha_s0[W +: W]), 32'd0);
        chk("rst_upd",  32'(upd_s0), 32'd0);

        run(4'd1, 1);
        chk("k1_fre0", 32'(fre_s0[0 +: W]), 32'd550);
        chk("k1_fre1", 32'(fre_s0[W +: W]), 32'd500);
        chk("k1_upd",  32'(upd_s0), 32'd1);
        run(4'd0, 1);
        chk("k1_upd_drop", 32'(upd_s0), 32'd0);

        run(4'd3, 19);
        run(4'd0, 1);
        chk("rep_pha0", 32'(pha_s0[0 +: W]), 32'd4000);

        run(4'd6, 1); run(4'd0, 1); run(4'd6, 1); run(4'd0, 1);
        run(4'd5, 1); run(4'd0, 1); run(4'd1, 1);
        chk("scl_ss",   32'(ss_s0), 32'd2);
        chk("scl_ch",   32'(ch_s0), 32'd1);
        chk("scl_fre1", 32'(fre_s0[W +: W]), 32'd1300);
        run(4'd0, 1);

        do_reset();
        repeat (10) begin run(4'd2, 1); run(4'd0, 1); end
        chk("dn10_wrap", 32'(fre_s0[0 +: W]), 32'd0);
        chk("dn10_sat",  32'(fre_s1[0 +: W]), 32'd0);
        run(4'd2, 1);
        chk("dn11_wrap", 32'(fre_s0[0 +: W]), 32'd65486);
        chk("dn11_sat",  32'(fre_s1[0 +: W]), 32'd0);
        chk("dn11_upd",  32'(upd_s1), 32'd1);
        run(4'd0, 1);

        do_reset();
        run(4'd4, 1);
        chk("pha_wrapdn", 32'(pha_s0[0 +: W]), 32'd64536);
        run(4'd0, 1);

        do_reset();
        run(4'd1, 12);
        chk("hold_pre", 32'(fre_s0[0 +: W]), 32'd600);
        rst = 1'b1;
        run(4'd1, 1);
        rst = 1'b0;
        chk("hold_rst", 32'(fre_s0[0 +: W]), 32'd500);
        run(4'd1, 1);
        chk("hold_press", 32'(fre_s0[0 +: W]), 32'd550);
        run(4'd1, 9);
        chk("hold_wait", 32'(fre_s0[0 +: W]), 32'd550);
        run(4'd1, 1);
        chk("hold_rep", 32'(fre_s0[0 +: W]), 32'd600);
        run(4'd0, 1);

        run(4'd3, 1); run(4'd0, 1);
        run(4'd5, 1); run(4'd0, 1);
        run(4'd1, 1); run(4'd3, 1); run(4'd0, 1);
        run(4'd7, 1);
        chk("clr_fre1", 32'(fre_s0[W +: W]), 32'd500);
        chk("clr_pha1", 32'(pha_s0[W +: W]), 32'd0);
        chk("clr_pha0", 32'(pha_s0[0 +: W]), 32'd1000);
        chk("clr_fre0", 32'(fre_s0[0 +: W]), 32'd600);
        run(4'd0, 1);

        repeat (150) begin
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) k = 4'($urandom_range(1, 7));
            n = $urandom_range(1, 25);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                run(k, 1);
                rst = 1'b0;
            end
            run(k, n);
            if ($urandom_range(0, 1) != 0) run(4'd0, 1);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
